// File: rtl/id_operand_fetch.sv
// Decode / operand-fetch stage of the multicycle RV32I core.
// Decodes one instruction at a time and fetches rs1/rs2 through the register
// file's re/finished handshake. The bundle is then offered downstream over
// valid/ready. The stage also owns the register file's write port for
// writeback requests.
module id_operand_fetch #(
  parameter int RF_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op_rs1_val,
  output logic [31:0] op_rs2_val,
  output logic [31:0] op_imm,
  output logic [4:0]  op_rd,
  output logic [6:0]  op_opcode,
  output logic [2:0]  op_funct3,
  output logic        op_funct7b5,
  output logic        op_rd_we,
  output logic        op_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  output logic        rf_re1,
  output logic        rf_re2,
  output logic [4:0]  rf_read_addr1,
  output logic [4:0]  rf_read_addr2,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,
  input  logic        rf_read_finished,
  output logic        rf_we,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  input  logic        rf_write_finished,
  output logic        err
);
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_S = 7'b0100011, OPC_B = 7'b1100011;
  localparam logic [6:0] OPC_I = 7'b0010011, OPC_L = 7'b0000011, OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam int TW = $clog2(RF_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_OUT, S_WB, S_WB_ACK} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          out_valid_q, out_valid_d, wb_ready_q, wb_ready_d, err_q, err_d;
  logic          rf_re1_q, rf_re1_d, rf_re2_q, rf_re2_d, rf_we_q, rf_we_d;
  logic [4:0]    rf_ra1_q, rf_ra1_d, rf_ra2_q, rf_ra2_d, rf_wa_q, rf_wa_d;
  logic [31:0]   rf_wd_q, rf_wd_d;
  logic [31:0]   rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]    rd_q, rd_d;
  logic [6:0]    opc_q, opc_d;
  logic [2:0]    f3_q, f3_d;
  logic          f7b5_q, f7b5_d, rd_we_q, rd_we_d, ill_q, ill_d;

  // Decode of the offered instruction word
  logic [6:0]  dec_opc;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use1, dec_use2, dec_wr, dec_ill, dec_re1, dec_re2;
  logic [31:0] dec_imm;
  logic        timeout;

  assign dec_opc = inst[6:0];
  assign dec_rd  = inst[11:7];
  assign dec_rs1 = inst[19:15];
  assign dec_rs2 = inst[24:20];
  assign dec_re1 = dec_use1 && (dec_rs1 != 5'd0);
  assign dec_re2 = dec_use2 && (dec_rs2 != 5'd0);
  assign timeout = (timer_q == TW'(RF_TIMEOUT - 1));

  // Opcode classification and immediate extraction
  always_comb begin
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    dec_imm  = 32'd0;
    case (dec_opc)
      OPC_R: begin dec_use1 = 1'b1; dec_use2 = 1'b1; dec_wr = 1'b1; end
      OPC_S: begin
        dec_use1 = 1'b1; dec_use2 = 1'b1;
        dec_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_B: begin
        dec_use1 = 1'b1; dec_use2 = 1'b1;
        dec_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_I, OPC_L, OPC_JALR: begin
        dec_use1 = 1'b1; dec_wr = 1'b1;
        dec_imm  = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_wr  = 1'b1;
        dec_imm = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        dec_wr  = 1'b1;
        dec_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;  timer_q <= '0;
      out_valid_q <= 1'b0; wb_ready_q <= 1'b0; err_q <= 1'b0;
      rf_re1_q <= 1'b0; rf_re2_q <= 1'b0; rf_we_q <= 1'b0;
      rf_ra1_q <= '0; rf_ra2_q <= '0; rf_wa_q <= '0; rf_wd_q <= '0;
      rs1_q <= '0; rs2_q <= '0; imm_q <= '0; rd_q <= '0; opc_q <= '0;
      f3_q <= '0; f7b5_q <= 1'b0; rd_we_q <= 1'b0; ill_q <= 1'b0;
    end else begin
      state_q <= state_d;  timer_q <= timer_d;
      out_valid_q <= out_valid_d; wb_ready_q <= wb_ready_d; err_q <= err_d;
      rf_re1_q <= rf_re1_d; rf_re2_q <= rf_re2_d; rf_we_q <= rf_we_d;
      rf_ra1_q <= rf_ra1_d; rf_ra2_q <= rf_ra2_d; rf_wa_q <= rf_wa_d; rf_wd_q <= rf_wd_d;
      rs1_q <= rs1_d; rs2_q <= rs2_d; imm_q <= imm_d; rd_q <= rd_d; opc_q <= opc_d;
      f3_q <= f3_d; f7b5_q <= f7b5_d; rd_we_q <= rd_we_d; ill_q <= ill_d;
    end
  end

  // Next state; writeback wins over a simultaneously offered instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (wb_valid)        state_d = (wb_rd == 5'd0) ? S_WB_ACK : S_WB;
        else if (inst_valid) state_d = (dec_re1 || dec_re2) ? S_READ : S_OUT;
      S_READ:
        if (rf_read_finished) state_d = S_OUT;
        else if (timeout)     state_d = S_IDLE;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      S_WB:     if (rf_write_finished || timeout) state_d = S_WB_ACK;
      S_WB_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values, derived from current and next state
  always_comb begin
    rf_ra1_d = rf_ra1_q; rf_ra2_d = rf_ra2_q; rf_wa_d = rf_wa_q; rf_wd_d = rf_wd_q;
    rs1_d = rs1_q; rs2_d = rs2_q; imm_d = imm_q; rd_d = rd_q; opc_d = opc_q;
    f3_d = f3_q; f7b5_d = f7b5_q; rd_we_d = rd_we_q; ill_d = ill_q;
    err_d = err_q;
    // timer restarts whenever a waiting state is (re)entered
    timer_d = '0;
    if ((state_q == S_READ || state_q == S_WB) && state_d == state_q)
      timer_d = timer_q + 1'b1;
    out_valid_d = (state_d == S_OUT);
    wb_ready_d  = (state_d == S_WB_ACK);
    rf_we_d     = (state_d == S_WB);
    rf_re1_d    = (state_d == S_READ) ? ((state_q == S_READ) ? rf_re1_q : dec_re1) : 1'b0;
    rf_re2_d    = (state_d == S_READ) ? ((state_q == S_READ) ? rf_re2_q : dec_re2) : 1'b0;
    case (state_q)
      S_IDLE:
        if (wb_valid) begin
          rf_wa_d = wb_rd;
          rf_wd_d = wb_data;
        end else if (inst_valid) begin
          rf_ra1_d = dec_re1 ? dec_rs1 : 5'd0;
          rf_ra2_d = dec_re2 ? dec_rs2 : 5'd0;
          rs1_d = 32'd0; rs2_d = 32'd0;
          imm_d = dec_imm; rd_d = dec_rd; opc_d = dec_opc;
          f3_d = inst[14:12]; f7b5_d = inst[30];
          rd_we_d = dec_wr && (dec_rd != 5'd0);
          ill_d = dec_ill;
        end
      S_READ:
        if (rf_read_finished) begin
          rs1_d = rf_re1_q ? rf_read_data1 : 32'd0;
          rs2_d = rf_re2_q ? rf_read_data2 : 32'd0;
        end else if (timeout) err_d = 1'b1;
      S_WB:
        if (!rf_write_finished && timeout) err_d = 1'b1;
      default: ;
    endcase
  end

  assign inst_ready    = (state_q == S_IDLE) && !wb_valid;
  assign out_valid     = out_valid_q;
  assign wb_ready      = wb_ready_q;
  assign err           = err_q;
  assign rf_re1        = rf_re1_q;
  assign rf_re2        = rf_re2_q;
  assign rf_read_addr1 = rf_ra1_q;
  assign rf_read_addr2 = rf_ra2_q;
  assign rf_we         = rf_we_q;
  assign rf_write_addr = rf_wa_q;
  assign rf_write_data = rf_wd_q;
  assign op_rs1_val    = rs1_q;
  assign op_rs2_val    = rs2_q;
  assign op_imm        = imm_q;
  assign op_rd         = rd_q;
  assign op_opcode     = opc_q;
  assign op_funct3     = f3_q;
  assign op_funct7b5   = f7b5_q;
  assign op_rd_we      = rd_we_q;
  assign op_illegal    = ill_q;
endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: a behavioural register file answers reads and
// writes at the negedge, expected bundles go to a queue when an instruction is
// issued and are popped when the DUT hands a bundle over.
module tb_id_operand_fetch;
  logic        clk = 1'b0, clr = 1'b1;
  logic        inst_valid = 1'b0, out_ready = 1'b1, wb_valid = 1'b0;
  logic [31:0] inst = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0;
  logic        inst_ready, out_valid, wb_ready, err;
  logic [31:0] op_rs1_val, op_rs2_val, op_imm;
  logic [4:0]  op_rd;
  logic [6:0]  op_opcode;
  logic [2:0]  op_funct3;
  logic        op_funct7b5, op_rd_we, op_illegal;
  logic        rf_re1, rf_re2, rf_we;
  logic [4:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [31:0] rf_read_data1 = '0, rf_read_data2 = '0, rf_write_data;
  logic        rf_read_finished = 1'b0, rf_write_finished = 1'b0;

  id_operand_fetch #(.RF_TIMEOUT(8)) dut (
    .clk(clk), .clr(clr), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .out_valid(out_valid), .out_ready(out_ready), .op_rs1_val(op_rs1_val),
    .op_rs2_val(op_rs2_val), .op_imm(op_imm), .op_rd(op_rd), .op_opcode(op_opcode),
    .op_funct3(op_funct3), .op_funct7b5(op_funct7b5), .op_rd_we(op_rd_we),
    .op_illegal(op_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ready(wb_ready), .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_read_addr1(rf_read_addr1),
    .rf_read_addr2(rf_read_addr2), .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2), .rf_read_finished(rf_read_finished), .rf_we(rf_we),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_finished(rf_write_finished), .err(err));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        re1, re2;
    logic [4:0]  a1, a2;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic        rd_we, ill;
  } vec_t;

  vec_t        tbl[7];
  vec_t        vq[$];
  logic [31:0] regs[32];
  logic        stall_rd = 1'b0;
  int          tests = 0, fails = 0;

  function automatic vec_t mk(input logic [31:0] i, input logic r1, input logic r2,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] im, input logic [4:0] rd,
                              input logic we, input logic il);
    vec_t v;
    v.inst = i; v.re1 = r1; v.re2 = r2; v.a1 = a1; v.a2 = a2;
    v.rs1 = v1; v.rs2 = v2; v.imm = im; v.rd = rd; v.rd_we = we; v.ill = il;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // register file model: answers whatever is requested, one negedge later
  always @(negedge clk) begin
    rf_read_finished  = (rf_re1 || rf_re2) && !stall_rd;
    rf_read_data1     = regs[rf_read_addr1];
    rf_read_data2     = regs[rf_read_addr2];
    rf_write_finished = rf_we;
    if (rf_we && rf_write_addr != 5'd0) regs[rf_write_addr] = rf_write_data;
  end

  // scoreboard: compare each handed-over bundle against the oldest expectation
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (vq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_bundle: got rd=%0d imm=0x%08h expected none", op_rd, op_imm);
      end else begin
        vec_t e;
        logic [6:0] eo;
        e  = vq.pop_front();
        eo = e.inst[6:0];
        chk("rs1_val", op_rs1_val, e.rs1);
        chk("rs2_val", op_rs2_val, e.rs2);
        chk("imm", op_imm, e.imm);
        chk("rd", 32'(op_rd), 32'(e.rd));
        chk("rd_we", 32'(op_rd_we), 32'(e.rd_we));
        chk("illegal", 32'(op_illegal), 32'(e.ill));
        chk("opcode", 32'(op_opcode), 32'(eo));
      end
    end
  end

  // offer an instruction and return #1 after the edge that accepted it
  task automatic send(input logic [31:0] i);
    int n;
    @(negedge clk);
    inst = i; inst_valid = 1'b1;
    n = 0;
    while (!inst_ready && n < 50) begin @(negedge clk); n++; end
    if (!inst_ready) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    vq.push_back(v);
    send(v.inst);
    chk("rf_re1", 32'(rf_re1), 32'(v.re1));
    chk("rf_re2", 32'(rf_re2), 32'(v.re2));
    if (v.re1) chk("rf_addr1", 32'(rf_read_addr1), 32'(v.a1));
    if (v.re2) chk("rf_addr2", 32'(rf_read_addr2), 32'(v.a2));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), (v.re1 || v.re2) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    vec_t v;
    tbl[0] = mk(32'h002081B3, 1'b1, 1'b1, 5'd1, 5'd2, 32'h5, 32'hFFFFFFFD, 32'h0, 5'd3, 1'b1, 1'b0);
    tbl[1] = mk(32'h00000513, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
    tbl[2] = mk(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b0);
    tbl[3] = mk(32'h0020A223, 1'b1, 1'b1, 5'd1, 5'd2, 32'h5, 32'hFFFFFFFD, 32'h4, 5'd4, 1'b0, 1'b0);
    tbl[4] = mk(32'hFF812203, 1'b1, 1'b0, 5'd2, 5'd0, 32'hFFFFFFFD, 32'h0, 32'hFFFFFFF8, 5'd4, 1'b1, 1'b0);
    tbl[5] = mk(32'h008000EF, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 5'd1, 1'b1, 1'b0);
    tbl[6] = mk(32'h0000007F, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'h5;
    regs[2] = 32'hFFFFFFFD;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rf_re", 32'({rf_re1, rf_re2}), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_op_imm", op_imm, 32'd0);
    chk("rst_rf_addr", 32'({rf_read_addr1, rf_read_addr2, rf_write_addr}), 32'd0);
    clr = 1'b0;
    #1 chk("idle_inst_ready", 32'(inst_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // lui with downstream stalled for three cycles
    v = mk(32'h800000B7, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h80000000, 5'd1, 1'b1, 1'b0);
    out_ready = 1'b0;
    vq.push_back(v);
    send(v.inst);
    chk("lui_rf_re", 32'({rf_re1, rf_re2}), 32'd0);
    chk("lui_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_imm", op_imm, 32'h80000000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 32'(out_valid), 32'd0);

    // writeback to x5 racing an instruction that then reads x5
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    v = mk(32'h00028333, 1'b1, 1'b0, 5'd5, 5'd0, 32'h1234, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
    vq.push_back(v);
    inst = v.inst; inst_valid = 1'b1;
    #1 chk("wb_blocks_inst", 32'(inst_ready), 32'd0);
    fork
      send(v.inst);
      begin
        @(posedge clk); #1;
        chk("wb_rf_we", 32'(rf_we), 32'd1);
        chk("wb_addr", 32'(rf_write_addr), 32'd5);
        chk("wb_data", rf_write_data, 32'h1234);
        n = 0;
        @(negedge clk);
        while (!wb_ready && n < 20) begin @(negedge clk); n++; end
        chk("wb_ready_seen", 32'(wb_ready), 32'd1);
        wb_valid = 1'b0;
        @(negedge clk);
        chk("wb_ready_pulse", 32'(wb_ready), 32'd0);
      end
    join
    n = 0;
    while (vq.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("wb_then_read_drained", 32'(vq.size()), 32'd0);

    // writeback to x0: acknowledged without touching the register file
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    n = 0;
    @(negedge clk);
    while (!wb_ready && n < 10) begin
      chk("wb0_no_we", 32'(rf_we), 32'd0);
      @(negedge clk); n++;
    end
    chk("wb0_ready", 32'(wb_ready), 32'd1);
    chk("wb0_no_we_ack", 32'(rf_we), 32'd0);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("wb0_pulse_end", 32'(wb_ready), 32'd0);

    // read timeout: register file never finishes
    stall_rd = 1'b1;
    send(32'h002081B3);
    chk("to_rf_re", 32'(rf_re1), 32'd1);
    n = 0;
    while (!err && n < 20) begin @(posedge clk); #1; n++; end
    chk("to_cycles", 32'(n), 32'd8);
    chk("to_rf_re_drop", 32'({rf_re1, rf_re2}), 32'd0);
    chk("to_no_valid", 32'(out_valid), 32'd0);
    chk("to_inst_ready", 32'(inst_ready), 32'd1);
    @(posedge clk); #1;
    chk("to_err_sticky", 32'(err), 32'd1);
    stall_rd = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_err", 32'(err), 32'd0);

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(vq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode stage of the multicycle RV32I CPU. Sits directly upstream of the register file.
- Accepts one 32-bit instruction per handshake and decodes fields and immediate.
- Fetches rs1/rs2 through the register file's re/finished read handshake and presents an operand bundle downstream over a valid/ready handshake.
- Also arbitrates writeback requests into the register file's we/finished write port.

Parameters:
RF_TIMEOUT, 8, max cycles to wait for rf_read_finished/rf_write_finished before abort

Ports:
clk  in  1  clock; all state updates on posedge
clr  in  1  synchronous active-high reset
inst_valid  in  1  instruction offered
inst  in  32  instruction word
inst_ready  out  1  combinational: state==IDLE && !wb_valid
out_valid  out  1  operand bundle valid
out_ready  in  1  downstream accepts bundle
op_rs1_val, op_rs2_val  out  32  operand values (0 if unused or x0)
op_imm  out  32  sign-extended immediate
op_rd  out  5  destination register
op_opcode  out  7  inst[6:0]
op_funct3  out  3  inst[14:12]
op_funct7b5  out  1  inst[30]
op_rd_we  out  1  instruction writes rd (0 when rd==0)
op_illegal  out  1  unknown opcode
wb_valid  in  1  writeback request
wb_rd  in  5  writeback register
wb_data  in  32  writeback value
wb_ready  out  1  one-cycle writeback acknowledge
rf_re1, rf_re2  out  1  register-file read enables
rf_read_addr1, rf_read_addr2  out  5  read addresses
rf_read_data1, rf_read_data2  in  32  read data
rf_read_finished  in  1  read-done flag from register file
rf_we  out  1  register-file write enable
rf_write_addr  out  5  write address
rf_write_data  out  32  write data
rf_write_finished  in  1  write-done flag
err  out  1  sticky timeout flag

Behaviour:
- Reset (clr=1 at posedge): state=IDLE, timer=0. All outputs 0: out_valid, wb_ready, rf_re*, rf_we, err, all op_* fields and rf_* addresses/data.
- States: IDLE, READ, OUT, WB, WB_ACK.
- IDLE, wb_valid=1 (priority over inst):
  - wb_rd==0: go WB_ACK with no RF write.
  - else: latch rd/data, drive rf_we=1, go WB.
- IDLE, inst_valid && inst_ready: latch inst, decode.
- Reads per opcode:
  - both rs1 and rs2: R 0110011, S 0100011, B 1100011.
  - rs1 only: I-ALU 0010011, load 0000011, JALR 1100111.
  - none: LUI 0110111, AUIPC 0010111, JAL 1101111.
  - unknown opcode: none, and op_illegal=1.
- op_rd_we=1 for R/I/load/JALR/LUI/AUIPC/JAL with rd!=0, else 0.
- Immediates follow standard I/S/B/U/J encodings; R-type and illegal give 0.
- Read path:
  - Any needed read with nonzero index: go READ with rf_reN=1 for needed nonzero regs only.
  - Otherwise go OUT directly, operands 0.
- READ: hold rf_re*/addresses stable. At the first posedge sampling rf_read_finished=1: capture data (force 0 for unrequested regs), drop rf_re*, go OUT.
- Latency: accept at edge T → out_valid high after T (no reads) or after T+1 (reads, register file returns at the intervening negedge).
- OUT: out_valid=1, bundle stable until out_valid && out_ready at posedge, then IDLE with out_valid=0.
- WB: hold rf_we/addr/data. On sampling rf_write_finished=1: drop rf_we, go WB_ACK.
- WB_ACK: wb_ready=1 for exactly one cycle, then IDLE. wb_valid is ignored during WB_ACK, so there is no double accept.
- Timeout: timer counts cycles in READ or WB and clears on state entry. On reaching RF_TIMEOUT:
  - set err=1 (sticky until clr) and drop rf_re*/rf_we.
  - READ → IDLE, instruction dropped, out_valid never asserted.
  - WB → WB_ACK, so the source is still released.
- clr mid-operation: returns to IDLE in that cycle and abandons any pending bundle or writeback.

Test Plan:
- Prefill x1=0x5, x2=0xFFFFFFFD; inst 0x002081B3 (add x3,x1,x2) accepted at edge T → rf_re1=rf_re2=1, addresses 1/2; out_valid at T+1 with rs1=0x5, rs2=0xFFFFFFFD, rd=3, op_rd_we=1.
- Inst 0x800000B7 (lui x1,0x80000) → no rf_re, out_valid one cycle after accept, imm=0x80000000. Hold out_ready=0 for 3 cycles → bundle stable; accept on 4th.
- Inst 0x00000513 (addi x10,x0,0) → no reads, rs1_val=0. Inst 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, op_rd_we=0.
- wb_valid=1 and inst_valid=1 in the same cycle with wb_rd=5, wb_data=0x1234 → inst_ready=0, rf_we=1, wb_ready one cycle. Then reading x5 returns 0x1234. wb_rd=0 → wb_ready pulses, rf_we never rises.
- Tie rf_read_finished=0 and issue an add → err=1 after 8 cycles, rf_re drops, out_valid stays 0, inst_ready returns. clr=1 → err=0.
- Opcode 0x7F → op_illegal=1, op_rd_we=0, no rf_re.
